// File: rtl/displ_pkg.sv
// Shared types and constants for the six-digit 7-segment display controller.
package displ_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  localparam int NUM_DIGITS = 6;

  // CTRL register field positions
  localparam int EN_LSB    = 0;
  localparam int DP_LSB    = 8;
  localparam int LZ_BIT    = 16;
  localparam int BLINK_BIT = 17;

  localparam logic [31:0] CTRL_RST  = 32'h0000_003F;
  localparam logic [31:0] CTRL_MASK = 32'h0003_3F3F;
  localparam logic [7:0]  BLANK_PAT = 8'hFF;

endpackage

// File: rtl/displ_7segs_ctrl_if.sv
// CPU-side register bus of the display controller.
interface displ_7segs_ctrl_if;

  logic        we;
  logic        addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;

  modport master (output we, addr, wdata, input rdata, busy);
  modport slave  (input we, addr, wdata, output rdata, busy);

endinterface

// File: rtl/dig_displ_7_segs.sv
// Hex nibble to active-low 7-segment pattern; bit 7 is the DP and is left off.
module dig_displ_7_segs (
  input  logic [3:0] digit,
  output logic [7:0] segs
);

  // Pure lookup of the glyph for one hex digit
  always_comb begin
    segs = 8'hFF;
    case (digit)
      4'h0: segs = 8'hC0;
      4'h1: segs = 8'hF9;
      4'h2: segs = 8'hA4;
      4'h3: segs = 8'hB0;
      4'h4: segs = 8'h99;
      4'h5: segs = 8'h92;
      4'h6: segs = 8'h82;
      4'h7: segs = 8'hF8;
      4'h8: segs = 8'h80;
      4'h9: segs = 8'h90;
      4'hA: segs = 8'h88;
      4'hB: segs = 8'h83;
      4'hC: segs = 8'hC6;
      4'hD: segs = 8'hA1;
      4'hE: segs = 8'h86;
      4'hF: segs = 8'h8E;
      default: segs = 8'hFF;
    endcase
  end

endmodule

// File: rtl/displ_7segs_ctrl.sv
// Memory-mapped controller for six 7-segment displays. A single decoder is
// time-shared across the digits; results land in a shadow buffer and are
// committed to the outputs together so a partial update is never visible.
module displ_7segs_ctrl
  import displ_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  displ_7segs_ctrl_if.slave  bus,
  output logic [7:0]         hex0,
  output logic [7:0]         hex1,
  output logic [7:0]         hex2,
  output logic [7:0]         hex3,
  output logic [7:0]         hex4,
  output logic [7:0]         hex5
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [2:0]    TOP_IDX    = 3'(NUM_DIGITS - 1);

  logic [23:0] value_q, value_nx;
  logic [31:0] ctrl_q, ctrl_nx;

  state_t      state;
  logic [2:0]  idx;
  logic        pending;
  logic        lz_run;
  logic [23:0] snap_value;
  logic [5:0]  snap_en;
  logic [5:0]  snap_dp;
  logic        snap_lz;
  logic [7:0]  shadow [NUM_DIGITS];
  logic [7:0]  hex_q  [NUM_DIGITS];
  logic [7:0]  hex_out [NUM_DIGITS];

  logic [3:0]  nibble;
  logic [7:0]  seg;
  logic [7:0]  pat;

  logic [CW-1:0] blink_cnt;
  logic          blink_phase;

  // Post-write view of the live registers, used both to update them and to snapshot
  always_comb begin
    value_nx = value_q;
    ctrl_nx  = ctrl_q;
    if (bus.we) begin
      if (bus.addr) ctrl_nx  = bus.wdata & CTRL_MASK;
      else          value_nx = bus.wdata[23:0];
    end
  end

  // Live VALUE/CTRL registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      ctrl_q  <= CTRL_RST;
    end else begin
      value_q <= value_nx;
      ctrl_q  <= ctrl_nx;
    end
  end

  assign bus.rdata = bus.addr ? ctrl_q : {8'h00, value_q};
  assign bus.busy  = (state != IDLE);

  assign nibble = snap_value[{idx, 2'b00} +: 4];

  dig_displ_7_segs u_dec (
    .digit (nibble),
    .segs  (seg)
  );

  // Apply DP, enable and leading-zero masking to the digit being scanned
  always_comb begin
    pat = seg;
    if (snap_dp[idx]) pat[7] = 1'b0;
    if (!snap_en[idx]) pat = BLANK_PAT;
    if (snap_lz && (idx != 3'd0) && (nibble == 4'h0) && lz_run) pat = BLANK_PAT;
  end

  // Update sequencer: snapshot, scan MS digit first, then commit all at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= TOP_IDX;
      pending    <= 1'b0;
      lz_run     <= 1'b1;
      snap_value <= '0;
      snap_en    <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= BLANK_PAT;
        hex_q[i]  <= BLANK_PAT;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.we) begin
            snap_value <= value_nx;
            snap_en    <= ctrl_nx[EN_LSB +: 6];
            snap_dp    <= ctrl_nx[DP_LSB +: 6];
            snap_lz    <= ctrl_nx[LZ_BIT];
            idx        <= TOP_IDX;
            lz_run     <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          shadow[idx] <= pat;
          lz_run      <= lz_run && (nibble == 4'h0);
          if (bus.we) pending <= 1'b1;
          if (idx == 3'd0) state <= COMMIT;
          else             idx   <= idx - 3'd1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= shadow[i];
          if (pending || bus.we) begin
            pending    <= 1'b0;
            snap_value <= value_nx;
            snap_en    <= ctrl_nx[EN_LSB +: 6];
            snap_dp    <= ctrl_nx[DP_LSB +: 6];
            snap_lz    <= ctrl_nx[LZ_BIT];
            idx        <= TOP_IDX;
            lz_run     <= 1'b1;
            state      <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink prescaler; held cleared while blinking is disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!ctrl_q[BLINK_BIT]) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Output mux from committed patterns and blink phase registers only
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      hex_out[i] = blink_phase ? BLANK_PAT : hex_q[i];
  end

  assign hex0 = hex_out[0];
  assign hex1 = hex_out[1];
  assign hex2 = hex_out[2];
  assign hex3 = hex_out[3];
  assign hex4 = hex_out[4];
  assign hex5 = hex_out[5];

endmodule

// File: doc/displ_7segs_ctrl.md
Name: displ_7segs_ctrl

Overview:
- Memory-mapped controller for the six 7-segment displays (HEX5..HEX0) on the DE10-Lite.
- CPU writes a 24-bit hex value and a control word. The block sequences one shared `dig_displ_7_segs` decoder across the six digits, one digit per cycle.
- It applies enable, decimal-point and leading-zero masking, then commits all six patterns at once. An optional blink prescaler can blank the displays.

Parameters:
- NUM_DIGITS, 6, number of displays scanned; fixed at 6 for this board.
- BLINK_DIV, 25_000_000, clk cycles per blink half-period; must be ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- we  in  1  write strobe; sampled at posedge clk
- addr  in  1  0 = VALUE register, 1 = CTRL register
- wdata  in  32  write data
- rdata  out  32  combinational readback of the selected register
- busy  out  1  update sequence in progress
- hex0..hex5  out  8 each  active-low segment patterns; bit 7 is DP; 1 means off

Behaviour:
Interface:
- Asynchronous reset `reset`, active-high; clock `clk`.

Registers:
- VALUE[23:0] = wdata[23:0]; wdata[31:24] is ignored. rdata = {8'h00, VALUE}.
- CTRL fields:
  - [5:0] en_mask (bit i enables hex i)
  - [13:8] dp_mask (bit i lights DP of hex i)
  - [16] lz_blank
  - [17] blink
  - Other bits read 0.

Reset values:
- VALUE = 0, CTRL = 32'h0000_003F.
- All hex outputs = 8'hFF.
- busy = 0, state = IDLE, pending = 0, blink counter = 0, blink phase = 0.
- Reset mid-scan aborts the sequence immediately with the same values.

Update trigger:
- Any accepted write (we=1 at edge k) to either register triggers an update.

States:
- IDLE: on a write, load snapshot ← post-write VALUE/CTRL, set idx ← 5, go to SCAN.
- SCAN: each edge processes digit idx, MS digit first, and writes shadow[idx].
  - Pattern = decoder(snapshot nibble idx).
  - If dp_mask[idx], clear bit 7.
  - If en_mask[idx] = 0, pattern = 8'hFF.
  - If lz_blank=1, idx≠0, nibble=0 and all higher nibbles are 0, pattern = 8'hFF (tracked by a lz_run flag).
  - Digit 0 is never leading-zero blanked.
  - On idx=0, go to COMMIT; otherwise idx ← idx−1.
- COMMIT: hex_q[5:0] ← shadow in a single edge.
  - If pending=1 or we=1 this edge: clear pending, snapshot ← post-write live registers, go to SCAN with idx=5.
  - Otherwise go to IDLE.

Timing and busy:
- A write at edge k produces new outputs after edge k+7 (6 SCAN edges + 1 COMMIT edge).
- busy = (state ≠ IDLE): high after edge k, low after edge k+7 unless restarted.

Writes while busy:
- In SCAN, the live register is updated immediately and pending ← 1.
- The snapshot is not disturbed.
- Multiple writes coalesce; the last value wins.
- Outputs never show a mix of old and new digits.

Blink:
- When CTRL.blink=1, the counter counts 0..BLINK_DIV−1 and toggles phase on wrap.
- Phase=1 forces all hex outputs to 8'hFF; output mux is driven from registers only.
- When CTRL.blink=0, counter and phase are held at 0.

Decomposition:
- Package `displ_pkg`:
  - state enum {IDLE, SCAN, COMMIT}
  - NUM_DIGITS
  - CTRL field positions (EN_LSB=0, DP_LSB=8, LZ_BIT=16, BLINK_BIT=17)
  - CTRL_RST = 32'h3F
  - BLANK_PAT = 8'hFF
- Sub-module: a single instance of the existing `dig_displ_7_segs`, shared by the scan index mux.

Test Plan:
1. Reset asserted then released -> all hex = FF, busy=0; read CTRL (addr=1) -> 0x0000003F; read VALUE -> 0.
2. Write VALUE 0x123456 at edge k -> busy=1 after k..k+7; hex5..0 = F9,A4,B0,99,92,82 after k+7, with hex still FF after k+6.
3. CTRL=0x1003F (lz_blank), VALUE 0x000A05:
   - hex5,4,3 = FF; hex2 = 88; hex1 = C0; hex0 = 92.
   - Then VALUE 0 -> hex0 = C0, all others FF.
4. VALUE 0x111111 at k, 0x222222 at k+3, 0x333333 at k+4:
   - all F9 after k+7; all B0 after k+14; 0x222222 is never displayed.
   - busy stays high continuously k..k+14.
5. CTRL=0x00105 (en 0x05, dp 0x01), VALUE 0x888888 -> hex0 = 00, hex2 = 80, hex1,3,4,5 = FF.
6. Blink with BLINK_DIV=4 -> displayed pattern alternates with FF every 4 cycles.
   - Clearing blink -> pattern steady.
   - Reset asserted during SCAN -> hex = FF, busy = 0 without waiting for a clock edge.
